// File: rtl/aoi211_pattern_checker.sv
// -----------------------------------------------------------------------------
// aoi211_pattern_checker
//
// Self-test harness for an AOI211 cell (ZN = !((A1&A2)|B|C)).
// It drives an exhaustive 16-vector sweep onto A1/A2/B/C, samples the observed
// ZN CAP_LAT+1 clock edges after each vector was launched, and compares it with
// the golden value. Mismatches are counted (saturating). A run ends with
// DONE/PASS.
//
// Parameters:
//   CAP_LAT : cycles from a vector being driven to ZN_OBS being sampled (1..8)
//   PASSES  : number of complete 16-vector sweeps per run (1..16)
//   ERR_W   : width of the saturating mismatch counter
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   asynchronous active-high reset
//   START      in   run request (level-sampled in IDLE/FIN)
//   ZN_OBS     in   observed ZN from the cell-under-test
//   A1,A2,B,C  out  stimulus, vector v -> {C,B,A2,A1} = v
//   BUSY       out  run in progress (DRIVE or DRAIN)
//   DONE       out  run complete, results valid
//   PASS       out  DONE & (ERR_CNT == 0)
//   ERR_CNT    out  saturating mismatch count
//   FAIL_VALID out  at least one mismatch logged
//   FAIL_VEC   out  vector index of the first mismatch
//   FAIL_ZN    out  observed ZN at the first mismatch
//
// Build option:
//   AOI211_CHK_FAILLOG_EN : when defined, the first-fail log (FAIL_VALID,
//   FAIL_VEC, FAIL_ZN) is built; otherwise those outputs are tied to 0.
// -----------------------------------------------------------------------------
module aoi211_pattern_checker #(
   parameter int CAP_LAT = 1,
   parameter int PASSES  = 1,
   parameter int ERR_W   = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             ZN_OBS,
   output logic             A1,
   output logic             A2,
   output logic             B,
   output logic             C,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic             FAIL_VALID,
   output logic [3:0]       FAIL_VEC,
   output logic             FAIL_ZN
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

`ifdef AOI211_CHK_FAILLOG_EN
   typedef struct packed {
      logic       vld;
      logic [3:0] vec;
      logic       gold;
   } pipe_t;
`else
   // Without the fail log the vector index is never needed downstream.
   typedef struct packed {
      logic vld;
      logic gold;
   } pipe_t;
`endif

   localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
   localparam logic [3:0]       SWEEP_END = 4'(PASSES - 1);
   localparam logic [3:0]       DRAIN_END = 4'(CAP_LAT - 1);

   // Golden response of the AOI211 cell for vector index v.
   function automatic logic golden_zn(input logic [3:0] v);
      return ~((v[0] & v[1]) | v[2] | v[3]);
   endfunction

   state_t           r_state;
   logic [3:0]       r_v;
   logic [3:0]       r_sweep;
   logic [3:0]       r_drain;
   logic [3:0]       r_stim;
   logic             r_drv;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [ERR_W-1:0] r_err;
   pipe_t            r_pipe [CAP_LAT];

   state_t           w_state_nx;
   logic [3:0]       w_v_nx;
   logic [3:0]       w_sweep_nx;
   logic [3:0]       w_drain_nx;
   logic             w_start_run;
   pipe_t            w_pipe_in;
   pipe_t            w_tap;
   logic             w_mis;
   logic [ERR_W-1:0] w_err_nx;

   // Next-state and sequencing counters for the run FSM.
   always_comb begin
      w_state_nx  = r_state;
      w_v_nx      = r_v;
      w_sweep_nx  = r_sweep;
      w_drain_nx  = r_drain;
      w_start_run = 1'b0;
      case (r_state)
         S_IDLE, S_FIN: begin
            if (START) begin
               w_start_run = 1'b1;
               w_state_nx  = S_DRIVE;
               w_v_nx      = 4'd0;
               w_sweep_nx  = 4'd0;
            end else begin
               w_state_nx  = r_state;
            end
         end
         S_DRIVE: begin
            w_v_nx = r_v + 4'd1;
            if (r_v == 4'd15) begin
               if (r_sweep == SWEEP_END) begin
                  w_state_nx = S_DRAIN;
                  w_drain_nx = 4'd0;
               end else begin
                  w_sweep_nx = r_sweep + 4'd1;
               end
            end else begin
               w_sweep_nx = r_sweep;
            end
         end
         S_DRAIN: begin
            if (r_drain == DRAIN_END) begin
               w_state_nx = S_FIN;
            end else begin
               w_drain_nx = r_drain + 4'd1;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Pipeline entry for the vector currently on the stimulus outputs.
   always_comb begin
      w_pipe_in      = '0;
      w_pipe_in.vld  = r_drv;
      w_pipe_in.gold = golden_zn(r_stim);
`ifdef AOI211_CHK_FAILLOG_EN
      w_pipe_in.vec  = r_stim;
`endif
   end

   // Compare at the tap; bubbles carry vld=0 and are never compared.
   always_comb begin
      w_tap = r_pipe[CAP_LAT-1];
      w_mis = w_tap.vld & ~w_start_run & (ZN_OBS != w_tap.gold);
   end

   // Saturating mismatch counter next value; cleared when a run starts.
   always_comb begin
      w_err_nx = r_err;
      if (w_start_run) begin
         w_err_nx = '0;
      end else if (w_mis && (r_err != ERR_MAX)) begin
         w_err_nx = r_err + ERR_ONE;
      end else begin
         w_err_nx = r_err;
      end
   end

   // FSM state, counters and all flop-driven outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_v     <= 4'd0;
         r_sweep <= 4'd0;
         r_drain <= 4'd0;
         r_stim  <= 4'd0;
         r_drv   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_err   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_v     <= w_v_nx;
         r_sweep <= w_sweep_nx;
         r_drain <= w_drain_nx;
         r_stim  <= (w_state_nx == S_DRIVE) ? w_v_nx : 4'd0;
         r_drv   <= (w_state_nx == S_DRIVE);
         r_busy  <= (w_state_nx == S_DRIVE) || (w_state_nx == S_DRAIN);
         r_done  <= (w_state_nx == S_FIN);
         r_pass  <= (w_state_nx == S_FIN) && (w_err_nx == '0);
         r_err   <= w_err_nx;
      end
   end

   // Compare pipeline: flushed when a run starts, shifts every cycle otherwise.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < CAP_LAT; i++) r_pipe[i] <= '0;
      end else if (w_start_run) begin
         for (int i = 0; i < CAP_LAT; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= w_pipe_in;
         for (int i = 1; i < CAP_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

`ifdef AOI211_CHK_FAILLOG_EN
   logic       r_fail_vld;
   logic [3:0] r_fail_vec;
   logic       r_fail_zn;

   // First-fail log: latched on the first mismatch of a run only.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_fail_vld <= 1'b0;
         r_fail_vec <= 4'd0;
         r_fail_zn  <= 1'b0;
      end else if (w_start_run) begin
         r_fail_vld <= 1'b0;
         r_fail_vec <= 4'd0;
         r_fail_zn  <= 1'b0;
      end else if (w_mis && !r_fail_vld) begin
         r_fail_vld <= 1'b1;
         r_fail_vec <= w_tap.vec;
         r_fail_zn  <= ZN_OBS;
      end else begin
         r_fail_vld <= r_fail_vld;
         r_fail_vec <= r_fail_vec;
         r_fail_zn  <= r_fail_zn;
      end
   end

   assign FAIL_VALID = r_fail_vld;
   assign FAIL_VEC   = r_fail_vec;
   assign FAIL_ZN    = r_fail_zn;
`else
   assign FAIL_VALID = 1'b0;
   assign FAIL_VEC   = 4'd0;
   assign FAIL_ZN    = 1'b0;
`endif

   assign A1      = r_stim[0];
   assign A2      = r_stim[1];
   assign B       = r_stim[2];
   assign C       = r_stim[3];
   assign BUSY    = r_busy;
   assign DONE    = r_done;
   assign PASS    = r_pass;
   assign ERR_CNT = r_err;

endmodule

// File: tb/tb_aoi211_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_aoi211_pattern_checker
//
// Three checker instances with different CAP_LAT/PASSES share clock and reset.
// Each has its own cell model (golden with a register delay, or stuck-at).
// Expected run results are queued when a run is launched and popped when
// DONE is observed.
// -----------------------------------------------------------------------------
module tb_aoi211_pattern_checker;

   localparam int N = 3;
`ifdef AOI211_CHK_FAILLOG_EN
   localparam bit LOG = 1'b1;
`else
   localparam bit LOG = 1'b0;
`endif

   typedef struct {
      int         busy;
      int         err;
      logic       pass;
      logic       fv;
      logic [3:0] fvec;
      logic       fzn;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start [N];
   logic       zn    [N];
   logic       a1 [N], a2 [N], b [N], c [N];
   logic       busy [N], done [N], pass [N], fvld [N], fzn [N];
   logic [4:0] err  [N];
   logic [3:0] fvec [N];
   int         mode [N];
   int         dly  [N];
   logic [3:0] mchain [N] = '{default: 4'd0};

   int         n_cmp = 0;
   int         n_mis = 0;
   exp_t       exp_q [$];
   logic [3:0] seen_vec [$];

   always #5 clk = ~clk;

   aoi211_pattern_checker #(.CAP_LAT(1), .PASSES(1), .ERR_W(5)) u_dut0 (
      .CLK(clk), .RST(rst), .START(start[0]), .ZN_OBS(zn[0]),
      .A1(a1[0]), .A2(a2[0]), .B(b[0]), .C(c[0]),
      .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .ERR_CNT(err[0]),
      .FAIL_VALID(fvld[0]), .FAIL_VEC(fvec[0]), .FAIL_ZN(fzn[0]));

   aoi211_pattern_checker #(.CAP_LAT(1), .PASSES(4), .ERR_W(5)) u_dut1 (
      .CLK(clk), .RST(rst), .START(start[1]), .ZN_OBS(zn[1]),
      .A1(a1[1]), .A2(a2[1]), .B(b[1]), .C(c[1]),
      .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .ERR_CNT(err[1]),
      .FAIL_VALID(fvld[1]), .FAIL_VEC(fvec[1]), .FAIL_ZN(fzn[1]));

   aoi211_pattern_checker #(.CAP_LAT(3), .PASSES(1), .ERR_W(5)) u_dut2 (
      .CLK(clk), .RST(rst), .START(start[2]), .ZN_OBS(zn[2]),
      .A1(a1[2]), .A2(a2[2]), .B(b[2]), .C(c[2]),
      .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .ERR_CNT(err[2]),
      .FAIL_VALID(fvld[2]), .FAIL_VEC(fvec[2]), .FAIL_ZN(fzn[2]));

   // Reference truth table: ZN is high only for vectors 0, 1 and 2.
   function automatic logic ref_zn(input logic [3:0] v);
      return (v < 4'd3);
   endfunction

   // Cell model: a chain of registers giving a delay of 1..4 clocks.
   always @(posedge clk) begin
      for (int k = 0; k < N; k++)
         mchain[k] <= {mchain[k][2:0], ref_zn({c[k], b[k], a2[k], a1[k]})};
   end

   // Model output select: 0 golden with delay, 1 stuck-at-0, 2 stuck-at-1.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         case (mode[k])
            1:       zn[k] = 1'b0;
            2:       zn[k] = 1'b1;
            default: zn[k] = mchain[k][dly[k]-1];
         endcase
      end
   end

   // Launch a run on instance d and return at the negedge where DONE is seen.
   task automatic do_run(input int d, input bit hold, output int busy_n, output bit to);
      busy_n = 0;
      to     = 1'b1;
      seen_vec.delete();
      @(negedge clk); start[d] = 1'b1;
      @(negedge clk); if (!hold) start[d] = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (done[d]) begin to = 1'b0; break; end
         if (busy[d]) begin
            busy_n++;
            seen_vec.push_back({c[d], b[d], a2[d], a1[d]});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < N; k++) begin start[k] = 1'b0; mode[k] = 0; dly[k] = 1; end
      repeat (3) @(negedge clk);
      for (int k = 0; k < N; k++) begin
         n_cmp++;
         if ({a1[k], a2[k], b[k], c[k], busy[k], done[k], pass[k], err[k], fvld[k], fvec[k], fzn[k]} !== 17'd0) begin
            n_mis++;
            $display("FAIL reset_outs[%0d]: got %b want all zero", k,
                     {a1[k], a2[k], b[k], c[k], busy[k], done[k], pass[k], err[k], fvld[k], fvec[k], fzn[k]});
         end
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_golden();
      int busy_n; bit to; exp_t e;
      mode[0] = 0; dly[0] = 1;
      exp_q.push_back('{busy: 17, err: 0, pass: 1'b1, fv: 1'b0, fvec: 4'd0, fzn: 1'b0});
      do_run(0, 1'b0, busy_n, to);
      e = exp_q.pop_front();
      n_cmp++; if (to) begin n_mis++; $display("FAIL golden_timeout: got no DONE want DONE"); end
      n_cmp++; if (busy_n !== e.busy) begin n_mis++; $display("FAIL golden_busy: got %0d want %0d", busy_n, e.busy); end
      n_cmp++; if ({done[0], pass[0], err[0], fvld[0]} !== {1'b1, e.pass, 5'(e.err), e.fv}) begin
         n_mis++; $display("FAIL golden_result: got done=%b pass=%b err=%0d fv=%b want 1 %b %0d %b",
                           done[0], pass[0], err[0], fvld[0], e.pass, e.err, e.fv);
      end
      n_cmp++;
      if (seen_vec.size() != 17) begin
         n_mis++; $display("FAIL golden_seq_len: got %0d want 17", seen_vec.size());
      end else begin
         for (int i = 0; i < 17; i++) begin
            logic [3:0] want;
            want = (i < 16) ? 4'(i) : 4'd0;
            if (seen_vec[i] !== want) begin
               n_mis++; $display("FAIL golden_seq[%0d]: got %0d want %0d", i, seen_vec[i], want);
               break;
            end
         end
      end
   endtask

   task automatic test_stuck0();
      int busy_n; bit to; exp_t e;
      mode[0] = 1;
      exp_q.push_back('{busy: 17, err: 3, pass: 1'b0, fv: LOG, fvec: 4'd0, fzn: 1'b0});
      do_run(0, 1'b0, busy_n, to);
      e = exp_q.pop_front();
      n_cmp++; if (to) begin n_mis++; $display("FAIL stuck0_timeout: got no DONE want DONE"); end
      n_cmp++; if (err[0] !== 5'(e.err)) begin n_mis++; $display("FAIL stuck0_err: got %0d want %0d", err[0], e.err); end
      n_cmp++; if (pass[0] !== e.pass) begin n_mis++; $display("FAIL stuck0_pass: got %b want %b", pass[0], e.pass); end
      n_cmp++; if ({fvld[0], fvec[0], fzn[0]} !== {e.fv, e.fvec, e.fzn}) begin
         n_mis++; $display("FAIL stuck0_log: got v=%b vec=%0d zn=%b want %b %0d %b",
                           fvld[0], fvec[0], fzn[0], e.fv, e.fvec, e.fzn);
      end
   endtask

   task automatic test_stuck1_sat();
      int busy_n; bit to; exp_t e;
      mode[1] = 2;
      exp_q.push_back('{busy: 65, err: 31, pass: 1'b0, fv: LOG, fvec: LOG ? 4'd3 : 4'd0, fzn: LOG});
      do_run(1, 1'b0, busy_n, to);
      e = exp_q.pop_front();
      n_cmp++; if (to) begin n_mis++; $display("FAIL sat_timeout: got no DONE want DONE"); end
      n_cmp++; if (busy_n !== e.busy) begin n_mis++; $display("FAIL sat_busy: got %0d want %0d", busy_n, e.busy); end
      n_cmp++; if (err[1] !== 5'(e.err)) begin n_mis++; $display("FAIL sat_err: got %0d want %0d", err[1], e.err); end
      n_cmp++; if (pass[1] !== e.pass) begin n_mis++; $display("FAIL sat_pass: got %b want %b", pass[1], e.pass); end
      n_cmp++; if ({fvld[1], fvec[1], fzn[1]} !== {e.fv, e.fvec, e.fzn}) begin
         n_mis++; $display("FAIL sat_log: got v=%b vec=%0d zn=%b want %b %0d %b",
                           fvld[1], fvec[1], fzn[1], e.fv, e.fvec, e.fzn);
      end
   endtask

   task automatic test_latency();
      int busy_n; bit to; exp_t e;
      // Delay matches CAP_LAT=3: clean run.
      mode[2] = 0; dly[2] = 3;
      exp_q.push_back('{busy: 19, err: 0, pass: 1'b1, fv: 1'b0, fvec: 4'd0, fzn: 1'b0});
      do_run(2, 1'b0, busy_n, to);
      e = exp_q.pop_front();
      n_cmp++; if (to) begin n_mis++; $display("FAIL lat3_timeout: got no DONE want DONE"); end
      n_cmp++; if (busy_n !== e.busy) begin n_mis++; $display("FAIL lat3_busy: got %0d want %0d", busy_n, e.busy); end
      n_cmp++; if ({pass[2], err[2]} !== {e.pass, 5'(e.err)}) begin
         n_mis++; $display("FAIL lat3_result: got pass=%b err=%0d want %b %0d", pass[2], err[2], e.pass, e.err);
      end
      // Delay 2: each sample sees the next vector's response; v=2 and v=15 differ.
      dly[2] = 2;
      exp_q.push_back('{busy: 19, err: 2, pass: 1'b0, fv: LOG, fvec: LOG ? 4'd2 : 4'd0, fzn: 1'b0});
      do_run(2, 1'b0, busy_n, to);
      e = exp_q.pop_front();
      n_cmp++; if (to) begin n_mis++; $display("FAIL lat2_timeout: got no DONE want DONE"); end
      n_cmp++; if ({pass[2], err[2]} !== {e.pass, 5'(e.err)}) begin
         n_mis++; $display("FAIL lat2_result: got pass=%b err=%0d want %b %0d", pass[2], err[2], e.pass, e.err);
      end
      n_cmp++; if ({fvld[2], fvec[2], fzn[2]} !== {e.fv, e.fvec, e.fzn}) begin
         n_mis++; $display("FAIL lat2_log: got v=%b vec=%0d zn=%b want %b %0d %b",
                           fvld[2], fvec[2], fzn[2], e.fv, e.fvec, e.fzn);
      end
   endtask

   task automatic test_mid_reset();
      int busy_n; bit to; bit hit; exp_t e;
      mode[0] = 1;                     // leave errors behind if the reset fails to clear
      hit = 1'b0;
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (busy[0] && ({c[0], b[0], a2[0], a1[0]} == 4'd7)) begin hit = 1'b1; break; end
         @(negedge clk);
      end
      n_cmp++; if (!hit) begin n_mis++; $display("FAIL midrst_reach_v7: got not reached want v=7"); end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({a1[0], a2[0], b[0], c[0], busy[0], done[0], pass[0], err[0], fvld[0], fvec[0], fzn[0]} !== 17'd0) begin
         n_mis++; $display("FAIL midrst_outs: got %b want all zero",
                           {a1[0], a2[0], b[0], c[0], busy[0], done[0], pass[0], err[0], fvld[0], fvec[0], fzn[0]});
      end
      @(negedge clk); rst = 1'b0;
      mode[0] = 0; dly[0] = 1;
      exp_q.push_back('{busy: 17, err: 0, pass: 1'b1, fv: 1'b0, fvec: 4'd0, fzn: 1'b0});
      do_run(0, 1'b0, busy_n, to);
      e = exp_q.pop_front();
      n_cmp++; if (to || busy_n !== e.busy) begin
         n_mis++; $display("FAIL midrst_rerun_busy: got %0d (timeout=%b) want %0d", busy_n, to, e.busy);
      end
      n_cmp++; if ({pass[0], err[0], fvld[0]} !== {e.pass, 5'(e.err), e.fv}) begin
         n_mis++; $display("FAIL midrst_rerun: got pass=%b err=%0d fv=%b want %b %0d %b",
                           pass[0], err[0], fvld[0], e.pass, e.err, e.fv);
      end
   endtask

   task automatic test_start_held();
      int busy_n; bit to; exp_t e;
      mode[0] = 1;
      exp_q.push_back('{busy: 17, err: 3, pass: 1'b0, fv: LOG, fvec: 4'd0, fzn: 1'b0});
      do_run(0, 1'b1, busy_n, to);
      e = exp_q.pop_front();
      n_cmp++; if (to || busy_n !== e.busy) begin
         n_mis++; $display("FAIL held_busy: got %0d (timeout=%b) want %0d", busy_n, to, e.busy);
      end
      n_cmp++; if ({done[0], err[0]} !== {1'b1, 5'(e.err)}) begin
         n_mis++; $display("FAIL held_fin: got done=%b err=%0d want 1 %0d", done[0], err[0], e.err);
      end
      @(negedge clk);
      n_cmp++; if ({done[0], busy[0], err[0]} !== {1'b0, 1'b1, 5'd0}) begin
         n_mis++; $display("FAIL held_restart: got done=%b busy=%b err=%0d want 0 1 0", done[0], busy[0], err[0]);
      end
      start[0] = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (done[0]) begin to = 1'b0; break; end
         @(negedge clk);
      end
      n_cmp++; if (to || err[0] !== 5'd3) begin
         n_mis++; $display("FAIL held_second_run: got err=%0d (timeout=%b) want 3", err[0], to);
      end
   endtask

   initial begin
      test_reset();
      test_golden();
      test_stuck0();
      test_stuck1_sat();
      test_latency();
      test_mid_reset();
      test_start_held();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
